// File: rtl/exec_phase_controller.sv
// Five-phase execution sequencer for the multicycle datapath.
// Sequences P1..P5, debounces the active-low exec button into single press pulses,
// retires HLT, inserts memory wait states and counts retired instructions.
module exec_phase_controller #(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned DB_W      = 16,
    parameter int unsigned MAX_STALL = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exec,
    input  logic        step_mode,
    input  logic        hlt,
    input  logic        mem_busy,
    output logic [2:0]  phase,
    output logic        running,
    output logic        halted,
    output logic        stall_err,
    output logic [15:0] instr_count
);

    localparam int unsigned StallW = (MAX_STALL == 0) ? 1 : $clog2(MAX_STALL + 1);

    typedef enum logic [2:0] {
        StIdle,
        StP1,
        StP2,
        StP3,
        StP4,
        StP5,
        StHalted
    } state_e;

    // Button path
    logic            sync1_q, sync2_q;
    logic            db_level_q, db_level_d;
    logic            db_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press;

    // Sequencer
    state_e              state_q, state_d;
    logic                stop_req_q, stop_req_d;
    logic                halt_pend_q, halt_pend_d;
    logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
    logic                stalling;
    logic                stall_err_q, stall_err_d;
    logic [15:0]         count_q, count_d;
    logic [2:0]          phase_q, phase_d;
    logic                running_q, running_d;
    logic                halted_q, halted_d;

    // Two-flop synchroniser for the asynchronous button; idles released (1)
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= exec;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive differing samples
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Debounced level and its one-cycle-delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            db_level_q <= 1'b1;
            db_prev_q  <= 1'b1;
            db_cnt_q   <= '0;
        end else begin
            db_level_q <= db_level_d;
            db_prev_q  <= db_level_q;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // Falling edge of the debounced level only; releases never produce a press
    assign press = db_prev_q & ~db_level_q;

    // Next-state logic: phase sequencing, stalls, stop/halt requests, retirement
    always_comb begin
        state_d     = state_q;
        stop_req_d  = stop_req_q;
        halt_pend_d = halt_pend_q;
        stall_cnt_d = '0;
        stalling    = 1'b0;
        stall_err_d = stall_err_q;
        count_d     = count_q;

        case (state_q)
            StIdle: begin
                if (press) begin
                    state_d    = StP1;
                    stop_req_d = 1'b0;
                end
            end
            StP1, StP4: begin
                if (press) begin
                    stop_req_d = 1'b1;
                end
                if ((state_q == StP4) && hlt) begin
                    halt_pend_d = 1'b1;
                end
                if (mem_busy) begin
                    // Hold the phase; counter saturates so the sticky flag cannot re-arm
                    stalling = 1'b1;
                    if (stall_cnt_q == StallW'(MAX_STALL)) begin
                        stall_cnt_d = stall_cnt_q;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = (state_q == StP1) ? StP2 : StP5;
                end
            end
            StP2, StP3: begin
                if (press) begin
                    stop_req_d = 1'b1;
                end
                if (hlt) begin
                    halt_pend_d = 1'b1;
                end
                state_d = (state_q == StP2) ? StP3 : StP4;
            end
            StP5: begin
                // Every P5 exit retires one instruction, HLT included.
                // A press or hlt arriving on the exit edge still counts for this instruction.
                count_d = count_q + 16'd1;
                if (halt_pend_q || hlt) begin
                    state_d     = StHalted;
                    halt_pend_d = 1'b0;
                    stop_req_d  = 1'b0;
                end else if (stop_req_q || press || step_mode) begin
                    state_d    = StIdle;
                    stop_req_d = 1'b0;
                end else begin
                    state_d = StP1;
                end
            end
            StHalted: begin
                // Leaving HALTED only returns to IDLE; a further press starts execution
                if (press) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (stalling && (stall_cnt_d == StallW'(MAX_STALL))) begin
            stall_err_d = 1'b1;
        end
    end

    // Output decode from the next state so phase/running/halted are registered
    always_comb begin
        case (state_d)
            StP1:    phase_d = 3'd1;
            StP2:    phase_d = 3'd2;
            StP3:    phase_d = 3'd3;
            StP4:    phase_d = 3'd4;
            StP5:    phase_d = 3'd5;
            default: phase_d = 3'd0;
        endcase
        running_d = (phase_d != 3'd0);
        halted_d  = (state_d == StHalted);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            stop_req_q  <= 1'b0;
            halt_pend_q <= 1'b0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
            count_q     <= '0;
            phase_q     <= 3'd0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_req_q  <= stop_req_d;
            halt_pend_q <= halt_pend_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
            count_q     <= count_d;
            phase_q     <= phase_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
        end
    end

    assign phase       = phase_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign stall_err   = stall_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_exec_phase_controller.sv
// Scoreboard bench for exec_phase_controller: stimulus pushes the expected output
// vector and the cycle it must appear in; a monitor pops on every output change.
module tb_exec_phase_controller;

    localparam int unsigned DbCycles = 4;
    localparam int unsigned MaxStall = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exec = 1'b1;
    logic        step_mode = 1'b0;
    logic        hlt = 1'b0;
    logic        mem_busy = 1'b0;
    logic [2:0]  phase;
    logic        running;
    logic        halted;
    logic        stall_err;
    logic [15:0] instr_count;

    exec_phase_controller #(
        .DB_CYCLES (DbCycles),
        .DB_W      (16),
        .MAX_STALL (MaxStall)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exec        (exec),
        .step_mode   (step_mode),
        .hlt         (hlt),
        .mem_busy    (mem_busy),
        .phase       (phase),
        .running     (running),
        .halted      (halted),
        .stall_err   (stall_err),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [21:0] vec;
        int unsigned at;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned base = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [21:0] prev_vec;

    // Vector layout: {phase, running, halted, stall_err, instr_count}
    function automatic logic [21:0] mk(logic [2:0] ph, logic run, logic hal, logic err,
                                       logic [15:0] cnt);
        return {ph, run, hal, err, cnt};
    endfunction

    task automatic push(int unsigned dt, logic [2:0] ph, logic run, logic hal, logic err,
                        logic [15:0] cnt);
        exp_t e;
        e.vec = mk(ph, run, hal, err, cnt);
        e.at  = base + dt;
        exp_q.push_back(e);
    endtask

    // One unstalled instruction: P1..P5 on consecutive cycles starting at dt
    task automatic push_instr(int unsigned dt, logic err, logic [15:0] cnt);
        for (int p = 1; p <= 5; p++) begin
            push(dt + p - 1, 3'(p), 1'b1, 1'b0, err, cnt);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic drained(string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        exec      = 1'b1;
        hlt       = 1'b0;
        mem_busy  = 1'b0;
        rst       = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_stall_err", 32'(stall_err), 32'd0);
        check("reset_instr_count", 32'(instr_count), 32'd0);
        mon_en = 1'b1;
    endtask

    // Monitor: every change of the output vector must match the next expectation
    always @(negedge clk) begin : monitor
        logic [21:0] cur;
        exp_t        e;
        cur = {phase, running, halted, stall_err, instr_count};
        if (!mon_en) begin
            prev_vec = cur;
        end else if (cur !== prev_vec) begin
            prev_vec = cur;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: cycle %0d got %h, required no change", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e.vec || cyc != e.at) begin
                    n_fail++;
                    $display("FAIL scoreboard: cycle %0d vec %h, required vec %h at cycle %0d",
                             cyc, cur, e.vec, e.at);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // Free run, then a press landing in P1 of the fourth instruction stops it
        do_reset();
        step_mode = 1'b0;
        base = cyc;
        push_instr(7, 1'b0, 16'd0);
        push_instr(12, 1'b0, 16'd1);
        push_instr(17, 1'b0, 16'd2);
        push_instr(22, 1'b0, 16'd3);
        push(27, 3'd0, 1'b0, 1'b0, 1'b0, 16'd4);
        exec = 1'b0;
        tick(10);
        exec = 1'b1;
        tick(6);
        exec = 1'b0;
        tick(6);
        check("free_run_count_after_15", 32'(instr_count), 32'd3);
        tick(2);
        exec = 1'b1;
        tick(12);
        drained("free_run_drain");

        // Single-step: three presses, three windows
        do_reset();
        step_mode = 1'b1;
        base = cyc;
        for (int k = 0; k < 3; k++) begin
            push_instr(20 * k + 7, 1'b0, 16'(k));
            push(20 * k + 12, 3'd0, 1'b0, 1'b0, 1'b0, 16'(k + 1));
        end
        for (int k = 0; k < 3; k++) begin
            exec = 1'b0;
            tick(8);
            exec = 1'b1;
            tick(12);
        end
        check("step_count", 32'(instr_count), 32'd3);
        drained("step_drain");

        // Bouncing button: toggles every 2 cycles, then settles low
        do_reset();
        step_mode = 1'b1;
        base = cyc;
        push_instr(27, 1'b0, 16'd0);
        push(32, 3'd0, 1'b0, 1'b0, 1'b0, 16'd1);
        for (int i = 0; i < 10; i++) begin
            exec = 1'(i % 2);
            tick(2);
        end
        exec = 1'b0;
        tick(10);
        exec = 1'b1;
        tick(15);
        drained("bounce_drain");

        // Wait states: 3 cycles in P1, 2 in P4 -> 10-cycle instruction, no error
        do_reset();
        step_mode = 1'b1;
        base = cyc;
        push(7, 3'd1, 1'b1, 1'b0, 1'b0, 16'd0);
        push(11, 3'd2, 1'b1, 1'b0, 1'b0, 16'd0);
        push(12, 3'd3, 1'b1, 1'b0, 1'b0, 16'd0);
        push(13, 3'd4, 1'b1, 1'b0, 1'b0, 16'd0);
        push(16, 3'd5, 1'b1, 1'b0, 1'b0, 16'd0);
        push(17, 3'd0, 1'b0, 1'b0, 1'b0, 16'd1);
        exec = 1'b0;
        tick(7);
        mem_busy = 1'b1;
        tick(3);
        mem_busy = 1'b0;
        exec = 1'b1;
        tick(3);
        mem_busy = 1'b1;
        tick(2);
        mem_busy = 1'b0;
        tick(15);
        check("stall_short_no_err", 32'(stall_err), 32'd0);
        drained("stall_short_drain");

        // Long P4 stall: error raised on the MAX_STALL-th cycle, phase holds at 4
        do_reset();
        step_mode = 1'b1;
        base = cyc;
        push(7, 3'd1, 1'b1, 1'b0, 1'b0, 16'd0);
        push(8, 3'd2, 1'b1, 1'b0, 1'b0, 16'd0);
        push(9, 3'd3, 1'b1, 1'b0, 1'b0, 16'd0);
        push(10, 3'd4, 1'b1, 1'b0, 1'b0, 16'd0);
        push(14, 3'd4, 1'b1, 1'b0, 1'b1, 16'd0);
        push(17, 3'd5, 1'b1, 1'b0, 1'b1, 16'd0);
        push(18, 3'd0, 1'b0, 1'b0, 1'b1, 16'd1);
        exec = 1'b0;
        tick(8);
        exec = 1'b1;
        tick(2);
        mem_busy = 1'b1;
        tick(6);
        mem_busy = 1'b0;
        tick(15);
        check("stall_err_sticky", 32'(stall_err), 32'd1);
        drained("stall_long_drain");

        // HLT in P3 of the second instruction; press -> IDLE; press -> run
        // (hlt held across IDLE and P1 of the last run must be ignored)
        do_reset();
        step_mode = 1'b0;
        base = cyc;
        push_instr(7, 1'b0, 16'd0);
        push_instr(12, 1'b0, 16'd1);
        push(17, 3'd0, 1'b0, 1'b1, 1'b0, 16'd2);
        push(27, 3'd0, 1'b0, 1'b0, 1'b0, 16'd2);
        push_instr(47, 1'b0, 16'd2);
        push(52, 3'd0, 1'b0, 1'b0, 1'b0, 16'd3);
        exec = 1'b0;
        tick(8);
        exec = 1'b1;
        tick(6);
        hlt = 1'b1;
        tick(1);
        hlt = 1'b0;
        tick(5);
        exec = 1'b0;
        tick(8);
        exec = 1'b1;
        tick(12);
        step_mode = 1'b1;
        exec = 1'b0;
        tick(5);
        hlt = 1'b1;
        tick(3);
        hlt = 1'b0;
        exec = 1'b1;
        tick(15);
        drained("halt_drain");

        // Reset asserted for one edge during P3 of the second instruction
        do_reset();
        step_mode = 1'b1;
        base = cyc;
        push_instr(7, 1'b0, 16'd0);
        push(12, 3'd0, 1'b0, 1'b0, 1'b0, 16'd1);
        push(27, 3'd1, 1'b1, 1'b0, 1'b0, 16'd1);
        push(28, 3'd2, 1'b1, 1'b0, 1'b0, 16'd1);
        push(29, 3'd3, 1'b1, 1'b0, 1'b0, 16'd1);
        push(30, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        exec = 1'b0;
        tick(8);
        exec = 1'b1;
        tick(12);
        exec = 1'b0;
        tick(8);
        exec = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(15);
        drained("mid_reset_drain");

        // Free run; press seen in P2 of the fourth instruction stops after its P5
        step_mode = 1'b0;
        base = cyc;
        push_instr(7, 1'b0, 16'd0);
        push_instr(12, 1'b0, 16'd1);
        push_instr(17, 1'b0, 16'd2);
        push_instr(22, 1'b0, 16'd3);
        push(27, 3'd0, 1'b0, 1'b0, 1'b0, 16'd4);
        exec = 1'b0;
        tick(8);
        exec = 1'b1;
        tick(9);
        exec = 1'b0;
        tick(8);
        exec = 1'b1;
        tick(15);
        check("stop_in_p2_count", 32'(instr_count), 32'd4);
        drained("stop_in_p2_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_phase_controller.md
Name: exec_phase_controller

Overview:
- Sequences the five-phase multicycle datapath: generates the 3-bit phase code that the control decoder, PC and register enables consume.
- Owns the run/stop/single-step behaviour of the active-low exec push-button: synchronisation, debounce and press detection.
- Handles HLT retirement, inserts wait states while memory is busy, and counts retired instructions for the board display.

Parameters:
DB_CYCLES, 50000, consecutive stable samples needed to accept a new button level (bench uses 4)
DB_W, 16, width of the debounce counter; must satisfy 2^DB_W > DB_CYCLES
MAX_STALL, 255, stall cycles allowed in one phase before stall_err is set

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  reset, active-low, synchronous
exec  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk
step_mode  input  1  1 = retire one instruction per press
hlt  input  1  HLT decoded by control; valid P2..P5
mem_busy  input  1  memory not ready; stalls P1 (fetch) and P4 (data access)
phase  output  3  000 idle/halted, 001..101 = P1..P5
running  output  1  1 while phase is P1..P5
halted  output  1  1 after an HLT has retired
stall_err  output  1  sticky; set when a stall reaches MAX_STALL
instr_count  output  16  number of retired instructions

Behaviour:
- Reset: rst==0 at a posedge is a synchronous reset and is honoured in any state, including mid-instruction and mid-stall.
- Reset values: phase=000, running=0, halted=0, stall_err=0, instr_count=0. Both sync flops, the debounced level and the previous debounced level are set to 1 (released). The debounce counter, stop_req, halt_pend and the stall counter are cleared.
- Button input path: exec passes through a two-flop synchroniser.
- Debounce: the debounced level changes only after the synchronised level differs from it for DB_CYCLES consecutive cycles. Any sample equal to the debounced level clears the counter.
- press is a one-cycle pulse on a debounced 1->0 transition. A button release never generates a press.
- States: IDLE, P1, P2, P3, P4, P5, HALTED. phase is a registered output; HALTED drives 000.
- IDLE:
  - press -> P1, running=1 on the same edge, stop_req cleared.
  - No press -> stay in IDLE.
- P1 and P4: if mem_busy=1, hold the phase and increment the stall counter; otherwise advance. The stall counter clears on every phase advance.
- P2 and P3: advance unconditionally after one cycle.
- stall_err:
  - Set when the stall counter reaches MAX_STALL.
  - The phase keeps holding while mem_busy=1; there is no forced abort.
  - Cleared only by reset.
- hlt:
  - hlt=1 sampled in any of P2..P5 sets halt_pend.
  - hlt is ignored in IDLE, P1 and HALTED.
- press while running (P1..P5) sets stop_req. A press that coincides with the P5 exit edge is counted for this instruction.
- P5 exit, evaluated in priority order:
  1. halt_pend -> HALTED: halted=1, running=0, halt_pend cleared.
  2. stop_req, or step_mode=1 -> IDLE: running=0, stop_req cleared.
  3. Otherwise -> P1.
- Retirement: instr_count increments by 1 on every P5 exit, including a HLT exit, and wraps FFFF->0000.
- HALTED: a press moves to IDLE and clears halted. It does not start execution; a second press is required.
- Minimum instruction latency is 5 cycles, P1 through P5, when mem_busy=0. Each mem_busy cycle in P1 or P4 adds one cycle.
- Free-run throughput is 1 instruction per 5 cycles: P5 is followed directly by P1, with no IDLE cycle.
- The exec level is ignored outside the press mechanism. Holding the button therefore never restarts execution.

Test Plan:
- Reset, then exec pulsed low for 10 cycles (DB_CYCLES=4), step_mode=0, mem_busy=0 -> phase sequences 001..101 repeating; running=1; instr_count=1 after the first P5 exit and 3 after 15 cycles of run.
- step_mode=1 with three separate presses -> exactly three 5-cycle instruction windows, phase=000 between them, instr_count=3.
- Button bounce: exec toggles every 2 cycles for 20 cycles, then settles low -> exactly one press, detected 2+4 cycles after settling; a single run starts.
- mem_busy=1 for 3 cycles in P1 and 2 cycles in P4 -> instruction takes 10 cycles; stall_err stays 0. With MAX_STALL=4 and mem_busy held for 6 cycles in P4 -> stall_err=1 and the phase holds at 100 until mem_busy drops.
- hlt=1 during P3 of the second instruction -> at P5 exit phase=000, halted=1, running=0, instr_count=2. A following press -> halted=0 with phase still 000; another press -> P1.
- Reset low for one edge during P3 -> next cycle phase=000 and all outputs at reset values. Press during P2 with step_mode=0 -> stops after P5, instr_count incremented once.
